// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: sync pulses, visible flag, pixel coordinates and line/frame strobes.
// Optional macro VGA_SYNC_FRAME_CNT_EN adds an 8-bit frame counter output (frame_cnt).
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk_vga,
    input  logic       rst_n,
    input  logic       en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Counters are only 10 bits wide, so longer rasters cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_cfg
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       von_q, von_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    // Next-state counters; every flag is decoded from the next coordinates so nothing lags them.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        von_d = von_q;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
`ifdef VGA_SYNC_FRAME_CNT_EN
        cnt_d = cnt_q;
`endif
        if (en) begin
            if (x_q >= H_LAST) begin
                x_d = 10'd0;
                if (y_q >= V_LAST) begin
                    y_d = 10'd0;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
                y_d = y_q;
            end
            hs_d  = ((x_d >= H_SYNC_FIRST) && (x_d <= H_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
            vs_d  = ((y_d >= V_SYNC_FIRST) && (y_d <= V_SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
            von_d = (x_d < H_VIS) && (y_d < V_VIS);
            ls_d  = (x_d == 10'd0);
            fs_d  = ls_d && (y_d == 10'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
            if (fs_d) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
`endif
        end else begin
            // Frozen: state holds, strobes already defaulted low so nothing is re-announced.
            x_d = x_q;
            y_d = y_q;
        end
    end

    // State and output registers; reset parks the raster on the last pixel of the frame.
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            x_q   <= H_LAST;
            y_q   <= V_LAST;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            von_q <= 1'b0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
`ifdef VGA_SYNC_FRAME_CNT_EN
            cnt_q <= 8'd0;
`endif
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            von_q <= von_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
`ifdef VGA_SYNC_FRAME_CNT_EN
            cnt_q <= cnt_d;
`endif
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign video_on    = von_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
`ifdef VGA_SYNC_FRAME_CNT_EN
    assign frame_cnt   = cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: 640x480 timing via a vector table, plus a tiny raster
// (15x10, active-high sync) for whole-frame counts, wraps and the optional frame counter.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    // Default 640x480 instance
    logic       rst_n, en;
    logic       hsync, vsync, video_on, line_start, frame_start;
    logic [9:0] pixel_x, pixel_y;

    // Small instance: H 8+2+3+2=15, V 6+1+2+1=10, sync active-high
    logic       s_rst_n, s_en;
    logic       s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
    logic [9:0] s_pixel_x, s_pixel_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt, s_frame_cnt;
`endif

    vga_sync_gen dut (
        .clk_vga    (clk),
        .rst_n      (rst_n),
        .en         (en),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .line_start (line_start),
        .frame_start(frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dut_s (
        .clk_vga    (clk),
        .rst_n      (s_rst_n),
        .en         (s_en),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .video_on   (s_video_on),
        .pixel_x    (s_pixel_x),
        .pixel_y    (s_pixel_y),
        .line_start (s_line_start),
        .frame_start(s_frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt  (s_frame_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int   adv;   // enabled/disabled edges to apply before sampling
        logic en;
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic von;
        logic ls;
        logic fs;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    task automatic check_main(input string tag, input int x, input int y, input logic hs,
                              input logic vs, input logic von, input logic ls, input logic fs);
        chk({tag, "_x"},   32'(pixel_x),     32'(x));
        chk({tag, "_y"},   32'(pixel_y),     32'(y));
        chk({tag, "_hs"},  32'(hsync),       32'(hs));
        chk({tag, "_vs"},  32'(vsync),       32'(vs));
        chk({tag, "_von"}, 32'(video_on),    32'(von));
        chk({tag, "_ls"},  32'(line_start),  32'(ls));
        chk({tag, "_fs"},  32'(frame_start), 32'(fs));
    endtask

    initial begin
        int fs_n, ls_n, vs_n, hs_n, von_n, oor_n;
        int vs_first_x, vs_first_y;

        //            adv   en    x    y   hs  vs  von ls  fs
        tbl[0]  = '{0,    1'b1, 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1,    1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{1,    1'b1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{638,  1'b1, 639,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1,    1'b1, 640,   0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{15,   1'b1, 655,   0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1,    1'b1, 656,   0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{95,   1'b1, 751,   0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1,    1'b1, 752,   0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{47,   1'b1, 799,   0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1,    1'b1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{7999, 1'b1, 799,  10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1,    1'b1,   0,  11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{7500, 1'b1, 300,  20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{10,   1'b0, 300,  20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1,    1'b1, 301,  20, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{499,  1'b1,   0,  21, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{3,    1'b0,   0,  21, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1,    1'b1,   1,  21, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{7599, 1'b1, 400,  30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{256,  1'b1, 656,  30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{5,    1'b0, 656,  30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{1,    1'b1, 657,  30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst_n   = 1'b0;
        en      = 1'b1;
        s_rst_n = 1'b0;
        s_en    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven run on the 640x480 instance
        for (int i = 0; i < NVEC; i++) begin
            en = tbl[i].en;
            if (tbl[i].adv > 0) begin
                repeat (tbl[i].adv) @(posedge clk);
                @(negedge clk);
            end
            check_main($sformatf("v%0d", i), tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs,
                       tbl[i].von, tbl[i].ls, tbl[i].fs);
        end

        // Mid-line reset with en still high: reset wins, then restart at (0,0)
        rst_n = 1'b0;
        en    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_main("rst_mid", 799, 524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_main("rst_rel", 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("rst_rel_cnt", 32'(frame_cnt), 32'd1);
`endif

        // Small raster: reset state (active-high sync, so inactive is 0)
        chk("s_rst_x",  32'(s_pixel_x),     32'd14);
        chk("s_rst_y",  32'(s_pixel_y),     32'd9);
        chk("s_rst_hs", 32'(s_hsync),       32'd0);
        chk("s_rst_vs", 32'(s_vsync),       32'd0);
        chk("s_rst_von",32'(s_video_on),    32'd0);
        chk("s_rst_fs", 32'(s_frame_start), 32'd0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("s_rst_cnt", 32'(s_frame_cnt), 32'd0);
`endif
        s_rst_n = 1'b1;
        s_en    = 1'b1;

        // One whole frame (150 pixels), tallying every flag
        fs_n = 0; ls_n = 0; vs_n = 0; hs_n = 0; von_n = 0; oor_n = 0;
        vs_first_x = -1; vs_first_y = -1;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 0) begin
                chk("s_first_x",  32'(s_pixel_x),     32'd0);
                chk("s_first_y",  32'(s_pixel_y),     32'd0);
                chk("s_first_fs", 32'(s_frame_start), 32'd1);
`ifdef VGA_SYNC_FRAME_CNT_EN
                chk("s_first_cnt", 32'(s_frame_cnt), 32'd1);
`endif
            end
            if (s_frame_start) fs_n++;
            if (s_line_start)  ls_n++;
            if (s_hsync)       hs_n++;
            if (s_video_on)    von_n++;
            if (s_vsync) begin
                if (vs_n == 0) begin
                    vs_first_x = int'(s_pixel_x);
                    vs_first_y = int'(s_pixel_y);
                end
                vs_n++;
            end
            if (s_pixel_x > 10'd14 || s_pixel_y > 10'd9) oor_n++;
        end
        chk("s_fs_count",  32'(fs_n),  32'd1);
        chk("s_ls_count",  32'(ls_n),  32'd10);
        chk("s_hs_count",  32'(hs_n),  32'd30);
        chk("s_vs_count",  32'(vs_n),  32'd30);
        chk("s_von_count", 32'(von_n), 32'd48);
        chk("s_oor_count", 32'(oor_n), 32'd0);
        chk("s_vs_first_x", 32'(vs_first_x), 32'd0);
        chk("s_vs_first_y", 32'(vs_first_y), 32'd7);
        chk("s_last_x", 32'(s_pixel_x), 32'd14);
        chk("s_last_y", 32'(s_pixel_y), 32'd9);

        // Frame wrap: (14,9) -> (0,0) with both strobes
        @(posedge clk);
        @(negedge clk);
        chk("s_wrap_x",  32'(s_pixel_x),     32'd0);
        chk("s_wrap_y",  32'(s_pixel_y),     32'd0);
        chk("s_wrap_ls", 32'(s_line_start),  32'd1);
        chk("s_wrap_fs", 32'(s_frame_start), 32'd1);

`ifdef VGA_SYNC_FRAME_CNT_EN
        chk("s_cnt_f2", 32'(s_frame_cnt), 32'd2);
        for (int f = 3; f <= 256; f++) begin
            repeat (150) @(posedge clk);
            @(negedge clk);
            chk($sformatf("s_cnt_f%0d", f), 32'(s_frame_cnt), 32'(f % 256));
        end
        s_en = 1'b0;
        repeat (150) @(posedge clk);
        @(negedge clk);
        chk("s_cnt_frozen", 32'(s_frame_cnt), 32'd0);
        chk("s_frozen_fs",  32'(s_frame_start), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
